// File: rtl/dmem_responder_if.sv
// Load/store port between the MIPS datapath (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [3:0]  be;
  logic [31:0] rd;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (output req, we, addr, wd, be, input rd, ready, err, busy);
  modport slave  (input req, we, addr, wd, be, output rd, ready, err, busy);
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with programmable wait states, byte-enable writes and
// an error response for misaligned or out-of-range addresses.
module dmem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clock,
  input  logic            reset,
  dmem_responder_if.slave bus
);

  generate
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("dmem_responder: WAIT_CYCLES must be in 0..15");
    end
  endgenerate

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_ERR} state_t;

  state_t                  state, next_state;
  logic [3:0]              cnt, cnt_next;
  logic                    capture, addr_bad, access, in_wait;
  logic                    cap_we;
  logic [DEPTH_LOG2-1:0]   cap_idx;
  logic [31:0]             cap_wd;
  logic [3:0]              cap_be;
  logic                    acc_we;
  logic [DEPTH_LOG2-1:0]   acc_idx;
  logic [31:0]             acc_wd;
  logic [3:0]              acc_be;
  logic [31:0]             rd_q;
  logic [31:0]             mem [DEPTH];

  assign addr_bad = (bus.addr[1:0] != 2'b00) || ((bus.addr >> (DEPTH_LOG2 + 2)) != 32'd0);

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    case (state)
      S_IDLE, S_RESP: begin
        if (bus.req) begin
          capture = 1'b1;
          if (addr_bad) begin
            next_state = S_ERR;
          end else if (WAIT_CYCLES == 0) begin
            next_state = S_RESP;
          end else begin
            next_state = S_WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end else begin
          next_state = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd1) begin
          next_state = S_RESP;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      S_ERR:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // With zero wait states the access happens on the capture edge itself, so it uses live inputs.
  assign in_wait = (state == S_WAIT);
  assign acc_we  = in_wait ? cap_we  : bus.we;
  assign acc_idx = in_wait ? cap_idx : bus.addr[DEPTH_LOG2+1:2];
  assign acc_wd  = in_wait ? cap_wd  : bus.wd;
  assign acc_be  = in_wait ? cap_be  : bus.be;
  assign access  = (next_state == S_RESP) && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      rd_q  <= 32'd0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      if (access && !acc_we) begin
        rd_q <= mem[acc_idx];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (capture) begin
      cap_we  <= bus.we;
      cap_idx <= bus.addr[DEPTH_LOG2+1:2];
      cap_wd  <= bus.wd;
      cap_be  <= bus.be;
    end
  end

  // Memory contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (access && acc_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_wd[8*i +: 8];
        end
      end
    end
  end

  assign bus.rd    = rd_q;
  assign bus.ready = (state == S_RESP) || (state == S_ERR);
  assign bus.err   = (state == S_ERR);
  assign bus.busy  = (state != S_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a cycle-level model predicts each response, a
// negedge monitor pops and compares whatever the selected instance presents.
module tb_dmem_responder;

  logic clock = 1'b0;
  logic reset = 1'b1;

  dmem_responder_if bus ();
  dmem_responder_if bus0 ();

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) dut  (.clock(clock), .reset(reset), .bus(bus));
  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (.clock(clock), .reset(reset), .bus(bus0));

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_fail = 0;
  int          accept_from = 0;
  bit          sel = 1'b0;
  bit          mon_on = 1'b0;
  logic [31:0] rd_model = 32'd0;
  logic [31:0] mem_model [32];

  logic        m_ready, m_err, m_busy;
  logic [31:0] m_rd;
  assign m_ready = sel ? bus0.ready : bus.ready;
  assign m_err   = sel ? bus0.err   : bus.err;
  assign m_busy  = sel ? bus0.busy  : bus.busy;
  assign m_rd    = sel ? bus0.rd    : bus.rd;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %h required %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic set_bus(input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
    bus.req  = sel ? 1'b0 : r;  bus.we  = w; bus.addr  = a; bus.wd  = d; bus.be  = b;
    bus0.req = sel ? r : 1'b0;  bus0.we = w; bus0.addr = a; bus0.wd = d; bus0.be = b;
  endtask

  // Predicts acceptance and response from the current cycle and the request itself.
  task automatic apply_stimulus(input bit r, input bit w, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] b,
                                input bit commit, output bit acc);
    exp_t e;
    int   c;
    int   wc;
    set_bus(r, w, a, d, b);
    c   = cyc;
    wc  = sel ? 0 : 2;
    acc = r && (c >= accept_from);
    e.cyc = 0; e.err = 1'b0; e.rd = 32'd0;
    if (acc) begin
      e.err = (a[1:0] != 2'b00) || (a >= 32'd4096);
      if (e.err) begin
        e.cyc       = c + 1;
        accept_from = c + 2;
      end else begin
        e.cyc       = c + wc + 1;
        accept_from = c + wc + 1;
        if (w) begin
          if (commit) begin
            for (int i = 0; i < 4; i++)
              if (b[i]) mem_model[a[6:2]][8*i +: 8] = d[8*i +: 8];
          end
        end else begin
          rd_model = mem_model[a[6:2]];
        end
      end
      e.rd = rd_model;
    end
    @(posedge clock);
    #1;
    if (acc) exp_q.push_back(e);
  endtask

  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input bit commit);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 40) begin
      apply_stimulus(1'b1, w, a, d, b, commit, acc);
      tries++;
    end
    if (!acc) check("accept_timeout", 32'(tries), 32'd0);
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 1'b1, acc);
  endtask

  task automatic do_reset();
    set_bus(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
    rd_model    = 32'd0;
    accept_from = cyc;
    mon_on      = 1'b1;
    check("reset_rd",    m_rd,           32'd0);
    check("reset_ready", 32'(m_ready),   32'd0);
    check("reset_err",   32'(m_err),     32'd0);
    check("reset_busy",  32'(m_busy),    32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    int          k;
    logic [31:0] wa;
    k  = $urandom_range(0, 9);
    wa = 32'($urandom_range(0, 31)) * 32'd4;
    if (k == 0) return wa + 32'($urandom_range(1, 3));
    if (k == 1) return 32'h0000_1000 | $urandom();
    return wa;
  endfunction

  task automatic check_output();
    exp_t e;
    check("busy", 32'(m_busy), 32'(exp_q.size() != 0));
    if (m_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_ready", 32'(m_ready), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_cycle", cyc, e.cyc);
        check("resp_err", 32'(m_err), 32'(e.err));
        check("resp_rd", m_rd, e.rd);
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      check("missing_ready", cyc, e.cyc);
    end
  endtask

  always @(negedge clock) begin
    if (mon_on) check_output();
  end

  task automatic random_phase(input int n);
    bit acc;
    for (int i = 0; i < n; i++) begin
      apply_stimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rand_addr(),
                     $urandom(), 4'($urandom_range(0, 15)), 1'b1, acc);
    end
    idle(6);
  endtask

  task automatic fill_memory();
    for (int k = 0; k < 32; k++) issue(1'b1, 32'(k * 4), $urandom(), 4'hF, 1'b1);
    idle(3);
  endtask

  initial begin
    set_bus(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    do_reset();
    fill_memory();

    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    issue(1'b0, 32'h10, 32'd0, 4'h0, 1'b1);
    idle(2);
    issue(1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b1);
    issue(1'b0, 32'h10, 32'd0, 4'h0, 1'b1);
    issue(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 1'b1);
    issue(1'b0, 32'h10, 32'd0, 4'h0, 1'b1);
    idle(2);

    issue(1'b0, 32'h13, 32'd0, 4'h0, 1'b1);
    idle(1);
    issue(1'b1, 32'h1000, 32'hBAD0BAD0, 4'hF, 1'b1);
    issue(1'b0, 32'h0, 32'd0, 4'h0, 1'b1);
    idle(3);

    issue(1'b1, 32'h20, 32'hA5A5A5A5, 4'hF, 1'b1);
    issue(1'b0, 32'h20, 32'd0, 4'h0, 1'b1);
    issue(1'b0, 32'h24, 32'd0, 4'h0, 1'b1);
    idle(4);

    // The CAFEF00D write is abandoned by reset during its first wait cycle.
    issue(1'b1, 32'h40, 32'h12345678, 4'hF, 1'b1);
    issue(1'b0, 32'h40, 32'd0, 4'h0, 1'b1);
    idle(4);
    issue(1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 1'b0);
    do_reset();
    issue(1'b0, 32'h40, 32'd0, 4'h0, 1'b1);
    idle(4);

    random_phase(300);

    sel = 1'b1;
    do_reset();
    fill_memory();
    issue(1'b1, 32'h0, 32'h00000001, 4'hF, 1'b1);
    issue(1'b0, 32'h0, 32'd0, 4'h0, 1'b1);
    idle(2);
    random_phase(200);

    check("drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
